// File: rtl/tdc_hit_collector.sv
// Frame-based TDC hit collector: timestamps SPAD hit cycles inside a start-triggered
// window, then drains them over a valid/ready stream. Optional overflow flag: TDC_OVF_EN.
module tdc_hit_collector #(
    parameter int N_CH     = 16,
    parameter int DATA_W   = 15,
    parameter int DEPTH    = 4,
    parameter int DEAD_CYC = 2,
    parameter int INT_W    = $clog2(N_CH + 1),
    parameter int NUM_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] range,
    input  logic [N_CH-1:0]   ch_hit,
    output logic [DATA_W-1:0] odata,
    output logic [INT_W-1:0]  oint,
    output logic [NUM_W-1:0]  onum,
    output logic              olast,
    output logic              ovalid,
    input  logic              oready,
    output logic              int_o,
    output logic              busy
`ifdef TDC_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int CNT_W  = NUM_W + 1;
    localparam int DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] range_q;
    logic [DATA_W-1:0] cnt;
    logic [CNT_W-1:0]  stored;
    logic [CNT_W-1:0]  stored_nxt;
    logic [NUM_W-1:0]  rd;
    logic [NUM_W-1:0]  rd_nxt;
    logic [DEAD_W-1:0] dead;
    logic [INT_W-1:0]  pop;
    logic              hit_any;
    logic              in_dead;
    logic              full;
    logic              hit_acc;
    logic              last_cyc;
    logic              xfer;

    logic [DATA_W-1:0] mem_ts  [DEPTH];
    logic [INT_W-1:0]  mem_int [DEPTH];

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + INT_W'(ch_hit[i]);
        end
    end

    always_comb begin
        hit_any    = |ch_hit;
        in_dead    = (dead != '0);
        full       = (stored == CNT_W'(DEPTH));
        hit_acc    = (state == S_COUNT) && hit_any && !in_dead && !full;
        stored_nxt = stored + CNT_W'(hit_acc);
        last_cyc   = (state == S_COUNT) && (cnt == range_q - DATA_W'(1));
        xfer       = ovalid && oready;
        rd_nxt     = rd + NUM_W'(1);
    end

    // NOTE: every combinational output gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (range == '0) ? S_DONE : S_COUNT;
            S_COUNT: if (last_cyc) state_nxt = (stored_nxt != '0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (xfer && olast) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_q <= '0;
            cnt     <= '0;
            stored  <= '0;
            rd      <= '0;
            dead    <= '0;
            odata   <= '0;
            oint    <= '0;
            onum    <= '0;
            olast   <= 1'b0;
            ovalid  <= 1'b0;
            int_o   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            int_o <= (state_nxt == S_DONE);
            busy  <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        range_q <= range;
                        cnt     <= '0;
                        stored  <= '0;
                        rd      <= '0;
                        dead    <= '0;
                    end
                end
                S_COUNT: begin
                    cnt <= cnt + DATA_W'(1);
                    if (hit_acc) begin
                        stored <= stored_nxt;
                        dead   <= DEAD_W'(DEAD_CYC);
                    end else if (in_dead) begin
                        dead <= dead - DEAD_W'(1);
                    end
                    // A hit in the final window cycle may itself be entry 0, so bypass the memory.
                    if (last_cyc && stored_nxt != '0) begin
                        ovalid <= 1'b1;
                        rd     <= '0;
                        onum   <= '0;
                        olast  <= (stored_nxt == CNT_W'(1));
                        if (stored == '0) begin
                            odata <= cnt;
                            oint  <= pop;
                        end else begin
                            odata <= mem_ts[0];
                            oint  <= mem_int[0];
                        end
                    end
                end
                S_DRAIN: begin
                    if (xfer) begin
                        if (olast) begin
                            ovalid <= 1'b0;
                            olast  <= 1'b0;
                        end else begin
                            rd    <= rd_nxt;
                            onum  <= rd_nxt;
                            odata <= mem_ts[rd_nxt];
                            oint  <= mem_int[rd_nxt];
                            olast <= ({1'b0, rd_nxt} == stored - CNT_W'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the hit memory has no reset; entries are only read after being written in the same frame.
    always_ff @(posedge clk) begin
        if (hit_acc) begin
            mem_ts[stored[NUM_W-1:0]]  <= cnt;
            mem_int[stored[NUM_W-1:0]] <= pop;
        end
    end

`ifdef TDC_OVF_EN
    logic ovf_hit;
    assign ovf_hit = (state == S_COUNT) && hit_any && !in_dead && full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         ovf <= 1'b0;
        else if (state == S_IDLE && start) ovf <= 1'b0;
        else if (ovf_hit)                ovf <= 1'b1;
    end
`endif

endmodule

// File: doc/tdc_hit_collector.md
Name: tdc_hit_collector

Overview:
- Parametrised frame-based TDC hit collector for an N-channel SPAD array.
- After a start pulse, counts a measurement window of `range` clock cycles.
- On each accepted hit cycle, records the coarse timestamp and the hit intensity (popcount of channel hits), with a programmable dead time.
- At window end, drains the stored hits over a valid/ready stream with index/last, then raises a one-cycle interrupt. Sits between the SPAD front-end and the core readout logic.

Parameters:
- N_CH, 16, number of SPAD hit channels.
- DATA_W, 15, timestamp and range width in bits.
- DEPTH, 4, maximum hits stored per frame; power of two, ≥2.
- DEAD_CYC, 2, cycles after an accepted hit during which further hits are ignored; 0 disables dead time.
- INT_W, $clog2(N_CH+1), intensity field width (derived).
- NUM_W, $clog2(DEPTH), entry index width (derived).

Ports:
- clk  in  1  single clock, all logic rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame start request, sampled only in IDLE.
- range  in  DATA_W  window length in cycles, sampled with start.
- ch_hit  in  N_CH  per-channel hit pulses, synchronous to clk.
- odata  out  DATA_W  hit timestamp (counter value).
- oint  out  INT_W  number of channels high in the hit cycle.
- onum  out  NUM_W  index of current entry, 0-based.
- olast  out  1  high on final entry of frame.
- ovalid  out  1  output data valid.
- oready  in  1  output data ready.
- int_o  out  1  one-cycle frame-complete interrupt.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - All outputs reset to 0, state IDLE, pointers/counters 0.
  - All outputs are registered.
- States: IDLE, COUNT, DRAIN, DONE.
- IDLE:
  - start=1 latches range. If range=0, go to DONE; else go to COUNT with cnt=0 and stored=0.
  - start in any other state is ignored.
- COUNT: cnt increments each cycle.
  - A cycle is a hit cycle when |ch_hit=1, not in dead time, and stored<DEPTH.
  - On a hit cycle, write {cnt, popcount(ch_hit)} to mem[stored], increment stored, and load dead counter with DEAD_CYC.
  - Hit in dead time: ignored silently.
  - Hit with stored=DEPTH: dropped.
  - When cnt=range-1 (hits in that cycle still captured), go to DRAIN if stored>0 (including a hit in that same cycle), else DONE.
  - cnt never wraps: range ≤ 2^DATA_W-1.
- DRAIN:
  - ovalid=1 from the first DRAIN cycle.
  - odata/oint = mem[rd], onum=rd, olast=(rd==stored-1).
  - Transfer on ovalid&oready. Outputs stay stable while ovalid&!oready.
  - After the olast transfer, ovalid drops next cycle and the FSM goes to DONE.
- DONE: int_o=1 for exactly one cycle, then IDLE. busy falls with int_o.
- Timing:
  - Start sampled at edge k gives cnt=0 in cycle k+1.
  - range=0 gives int_o high in cycle k+1 and no stream beats.
- Simultaneous multi-channel hits form one entry. oint = popcount, range 1..N_CH.
- Reset mid-operation discards the frame. ovalid and int_o drop asynchronously.

Optional Feature:
- Macro TDC_OVF_EN.
- Defined: adds output port ovf (1 bit).
  - Set when a hit outside dead time arrives with stored=DEPTH.
  - Sticky until the next accepted start or rst.
- Undefined: no ovf port. Overflow hits are dropped with no indication.

Test Plan:
- N_CH=16, range=10, start; ch_hit=16'h000F at cnt=3 -> one beat: odata=3, oint=4, onum=0, olast=1; int_o one cycle, one cycle after the handshake.
- DEAD_CYC=2; hits at cnt=3,4,5,6 -> two beats: odata=3, then 6 (olast=1).
- DEPTH=4, range=20; single-channel hits at cnt=1,5,9,13,17 -> four beats odata=1,5,9,13, onum 0..3, olast on 13; with TDC_OVF_EN, ovf=1 after cnt=17 and cleared by next start.
- Backpressure: oready=0 for 3 cycles during DRAIN -> ovalid, odata, onum held constant; transfers resume in order when oready=1.
- range=0 -> ovalid never asserts; int_o high in cycle after start; busy high for 1 cycle.
- rst pulse mid-DRAIN -> ovalid/busy 0 immediately; start asserted during COUNT has no effect on cnt or stored.
